// File: rtl/cpu_pkg.sv
// Shared CPU constants and types: instruction width, halt opcode, fetch FSM states.
// Decode imports this package for the same opcode constants.
package cpu_pkg;

    localparam int INSTR_W = 32;
    localparam logic [5:0] OP_HALT = 6'b111111;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    function automatic logic is_halt(input logic [INSTR_W-1:0] word);
        return word[31:26] == OP_HALT;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: run/stall/redirect controls, instruction-memory load port,
// and the fetched-instruction outputs presented to decode.
interface instr_fetch_unit_if #(
    parameter int IMEM_DEPTH = 64,
    parameter int AW         = $clog2(IMEM_DEPTH)
);
    import cpu_pkg::*;

    logic               en;
    logic               stall;
    logic               branch_taken;
    logic [31:0]        branch_target;
    logic               imem_we;
    logic [AW-1:0]      imem_waddr;
    logic [INSTR_W-1:0] imem_wdata;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic [31:0]        pc_out;
    logic [31:0]        pc_plus4;
    logic               halted;

    // master: the control/decode side driving the fetch unit
    modport master (
        output en, stall, branch_taken, branch_target,
        output imem_we, imem_waddr, imem_wdata,
        input  instr, instr_valid, pc_out, pc_plus4, halted
    );

    modport slave (
        input  en, stall, branch_taken, branch_target,
        input  imem_we, imem_waddr, imem_wdata,
        output instr, instr_valid, pc_out, pc_plus4, halted
    );

endinterface

// File: rtl/instr_rom.sv
// Writable instruction store: synchronous write, combinational read.
// No reset on the array so a loaded program survives a core reset.
module instr_rom
    import cpu_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // A write and a fetch to the same word on one edge sees the old word.
    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, RUN/HALT state, registered instruction/pc outputs.
// Redirect beats stall and inserts one bubble; a fetched halt opcode parks the unit until reset.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int          IMEM_DEPTH = 64,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    instr_fetch_unit_if.slave bus
);

    localparam int AW = $clog2(IMEM_DEPTH);

    fetch_state_t       state;
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr_q;
    logic [31:0]        pc_out_q;
    logic               valid_q;
    logic [INSTR_W-1:0] rdata;
    logic [31:0]        redirect_pc;

    instr_rom #(.DEPTH(IMEM_DEPTH)) u_rom (
        .clk   (clk),
        .we    (bus.imem_we),
        .waddr (bus.imem_waddr),
        .wdata (bus.imem_wdata),
        .raddr (pc[AW+1:2]),
        .rdata (rdata)
    );

    assign redirect_pc = bus.branch_target & ~32'h3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            pc       <= RESET_PC;
            instr_q  <= '0;
            pc_out_q <= RESET_PC;
            valid_q  <= 1'b0;
        end else if (bus.en) begin
            unique case (state)
                RUN: begin
                    if (bus.branch_taken) begin
                        pc      <= redirect_pc;
                        valid_q <= 1'b0;
                    end else if (!bus.stall) begin
                        instr_q  <= rdata;
                        pc_out_q <= pc;
                        valid_q  <= 1'b1;
                        pc       <= pc + 32'd4;
                        // The halt word itself is still handed to decode.
                        if (is_halt(rdata)) state <= HALT;
                    end
                end
                HALT: begin
                    if (!bus.stall) valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.instr       = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.pc_out      = pc_out_q;
    assign bus.pc_plus4    = pc_out_q + 32'd4;
    assign bus.halted      = (state == HALT);

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage for the single-cycle datapath: holds the program counter, reads a writable instruction memory, and presents one registered instruction per cycle to the decode/execute stage (register file, ALU, data memory). Supports downstream stall, branch/jump redirect with a one-cycle bubble, and a halt opcode. Replaces the switch-selected fixed-instruction scheme with a real sequenced program.

## Interface
- IMEM_DEPTH, 64, instruction words in memory (power of two); AW = $clog2(IMEM_DEPTH)
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned)
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low
- en  in  1  run enable; 0 freezes PC and outputs (no fetch)
- stall  in  1  decode stage not ready; holds current instr/pc/instr_valid
- branch_taken  in  1  redirect request from execute
- branch_target  in  32  redirect byte address; bits [1:0] ignored (forced 0)
- imem_we  in  1  instruction-memory load strobe
- imem_waddr  in  AW  word index to write
- imem_wdata  in  32  instruction word to write
- instr  out  32  fetched instruction
- instr_valid  out  1  instr/pc_out hold a real instruction
- pc_out  out  32  byte address of instr
- pc_plus4  out  32  pc_out + 4 (link/branch base)
- halted  out  1  fetch stopped by halt opcode

## Operation
- States: RUN, HALT (enum in package). Reset -> RUN.
- Fire condition: state==RUN & en & ~stall.
- On fire, no branch: instr <= imem[pc[AW+1:2]]; pc_out <= pc; instr_valid <= 1; pc <= pc + 4.
- branch_taken (state==RUN & en) has priority over stall and normal fetch: pc <= {branch_target[31:2],2'b00}; instr_valid <= 0 (bubble); instr/pc_out unchanged.
- stall without branch: all registers hold; instr_valid unchanged.
- en=0: all registers hold, including instr_valid.
- Halt: if the word fetched on a fire has opcode [31:26]==OP_HALT (6'b111111), it is still emitted with instr_valid=1; state -> HALT same edge. In HALT: no fetch, pc frozen, instr_valid <= 0 on next non-stalled cycle, halted=1, branch_taken ignored. Exit only via rst.
- PC arithmetic: 32-bit, wraps at 2^32; memory index = pc[AW+1:2], so addresses beyond depth alias modulo IMEM_DEPTH.
- imem write: synchronous on clk when imem_we, any state; same-edge fetch from the same index returns old word. Memory contents not cleared by rst.

## Timing
- Reset values: pc=RESET_PC, instr=32'h0, pc_out=RESET_PC, pc_plus4=RESET_PC+4, instr_valid=0, halted=0, state=RUN.
- Fetch latency 1 cycle: fire at edge N -> instr valid after edge N.
- First instruction valid one cycle after rst deasserts (with en=1, stall=0).
- Branch penalty: exactly one bubble; target instruction valid two edges after branch_taken sampled.
- pc_plus4 combinational from pc_out.
- rst asserted mid-run: all outputs return to reset values immediately (async), including from HALT.

## Structure
- cpu_pkg: INSTR_W=32, OP_HALT, fetch_state_t {RUN, HALT}; shared with decode for opcode constants.
- Sub-module instr_rom: IMEM_DEPTH x 32 array, synchronous write port, combinational read port.
- Top of fetch unit: PC register, state register, output registers, next-PC mux.

## Test plan
- Reset, load 0x0000_0000/0x9000_4000/0xB000_4000 at words 0-2, en=1 -> instr sequence valid with pc_out 0,4,8 on consecutive cycles.
- stall=1 for 3 cycles while pc_out=4 -> instr, pc_out=4, instr_valid=1 held; resumes with pc_out=8.
- branch_taken with branch_target=0x0000_0013 at pc_out=4 -> one cycle instr_valid=0, then pc_out=0x10 with imem[4].
- Word 3 = 0xFC00_0000 (halt) -> emitted valid at pc_out=0xC, then instr_valid=0, halted=1; later branch_taken ignored.
- PC at 0xFC with IMEM_DEPTH=64 -> next fetch pc_out=0x100 returns imem[0] (alias).
- rst pulled low mid-run while stall=1 -> outputs immediately reset values; first fetch after release at pc_out=RESET_PC.
